// File: rtl/ast_adc_rsp.sv
// AST-side ADC responder: power-up delay, per-channel conversion latency and one-hot request handshake.
// Optional result dither is enabled by defining AST_ADC_NOISE_EN.
module ast_adc_rsp #(
    parameter int AdcChannels  = 2,
    parameter int AdcDataWidth = 10,
    parameter int PwrUpCyc     = 8,
    parameter int ConvCyc      = 12
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 adc_pd_i,
    input  logic [AdcChannels-1:0]               adc_chnsel_i,
    input  logic [AdcChannels*AdcDataWidth-1:0]  chn_val_i,
    output logic [AdcDataWidth-1:0]              adc_d_o,
    output logic                                 adc_d_val_o,
    output logic                                 adc_busy_o,
    output logic                                 adc_err_o
);

    localparam int MaxCyc = (PwrUpCyc > ConvCyc) ? PwrUpCyc : ConvCyc;
    localparam int CntW   = $clog2(MaxCyc + 1);
    localparam int ChW    = (AdcChannels > 1) ? $clog2(AdcChannels) : 1;
    localparam int W      = AdcDataWidth;

    typedef enum logic [2:0] {
        ST_OFF,
        ST_PWRUP,
        ST_IDLE,
        ST_CONV,
        ST_DONE
    } state_e;

    state_e                 r_state;
    state_e                 w_state_next;
    logic [CntW-1:0]        r_cnt;
    logic [CntW-1:0]        w_cnt_next;
    logic [AdcChannels-1:0] r_sel;
    logic [AdcChannels-1:0] w_sel_next;
    logic [AdcChannels-1:0] r_err_sel;
    logic                   r_err_hold;
    logic                   w_err_hold_next;
    logic [W-1:0]           r_sample;
    logic [W-1:0]           w_sample_next;
    logic [W-1:0]           r_d;
    logic [W-1:0]           w_d_next;
    logic                   r_dval;
    logic                   w_dval_next;
    logic                   r_busy;
    logic                   w_busy_next;
    logic                   r_err;
    logic                   w_err_next;
    logic                   w_done;
    logic                   w_multi;
    logic                   w_onehot;
    logic [ChW-1:0]         w_idx;
    logic [W-1:0]           w_chn_val [AdcChannels];
    logic [W-1:0]           w_result;

    for (genvar gi = 0; gi < AdcChannels; gi++) begin : g_chn
        assign w_chn_val[gi] = chn_val_i[gi*W +: W];
    end

    assign w_multi  = (adc_chnsel_i & (adc_chnsel_i - AdcChannels'(1))) != '0;
    assign w_onehot = (adc_chnsel_i != '0) && !w_multi;

    always_comb begin
        w_idx = '0;
        for (int k = 0; k < AdcChannels; k++) begin
            if (adc_chnsel_i[k]) w_idx = ChW'(k);
        end
    end

`ifdef AST_ADC_NOISE_EN
    // Dither of -1/0/+1 picked by the LFSR, saturating at both rails.
    logic [7:0] r_lfsr;

    always_comb begin
        w_result = r_sample;
        case (r_lfsr[1:0])
            2'b01:   if (r_sample != {W{1'b1}}) w_result = r_sample + 1'b1;
            2'b10:   if (r_sample != {W{1'b0}}) w_result = r_sample - 1'b1;
            default: w_result = r_sample;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_lfsr <= 8'hA5;
        end else if (w_done) begin
            r_lfsr <= {1'b0, r_lfsr[7:1]} ^ (r_lfsr[0] ? 8'hB8 : 8'h00);
        end
    end
`else
    assign w_result = r_sample;
`endif

    always_comb begin
        w_state_next    = r_state;
        w_cnt_next      = r_cnt;
        w_sel_next      = r_sel;
        w_sample_next   = r_sample;
        w_d_next        = r_d;
        w_dval_next     = 1'b0;
        w_err_next      = 1'b0;
        w_err_hold_next = 1'b0;
        w_done          = 1'b0;

        if (adc_pd_i) begin
            // Power-down dominates everything, including a completing conversion.
            w_state_next = ST_OFF;
            w_cnt_next   = '0;
            w_d_next     = '0;
        end else begin
            case (r_state)
                ST_OFF: begin
                    w_state_next = ST_PWRUP;
                    w_cnt_next   = CntW'(PwrUpCyc);
                end
                ST_PWRUP: begin
                    if (r_cnt <= CntW'(1)) begin
                        w_state_next = ST_IDLE;
                        w_cnt_next   = '0;
                    end else begin
                        w_cnt_next = r_cnt - CntW'(1);
                    end
                end
                ST_IDLE: begin
                    if (w_onehot) begin
                        w_state_next  = ST_CONV;
                        w_cnt_next    = CntW'(ConvCyc - 1);
                        w_sel_next    = adc_chnsel_i;
                        w_sample_next = w_chn_val[w_idx];
                    end else if (w_multi) begin
                        // Flag a multi-hot select once, not on every cycle it is held.
                        w_err_hold_next = 1'b1;
                        w_err_next      = !(r_err_hold && (adc_chnsel_i == r_err_sel));
                    end
                end
                ST_CONV: begin
                    if (adc_chnsel_i != r_sel) begin
                        w_state_next = ST_IDLE;
                        w_cnt_next   = '0;
                        w_err_next   = 1'b1;
                    end else if (r_cnt == '0) begin
                        w_state_next = ST_DONE;
                        w_dval_next  = 1'b1;
                        w_d_next     = w_result;
                        w_done       = 1'b1;
                    end else begin
                        w_cnt_next = r_cnt - CntW'(1);
                    end
                end
                ST_DONE: begin
                    if (adc_chnsel_i == '0) w_state_next = ST_IDLE;
                end
                default: begin
                    w_state_next = ST_OFF;
                end
            endcase
        end

        w_busy_next = (w_state_next == ST_PWRUP) || (w_state_next == ST_CONV);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= ST_OFF;
            r_cnt      <= '0;
            r_sel      <= '0;
            r_err_sel  <= '0;
            r_err_hold <= 1'b0;
            r_sample   <= '0;
            r_d        <= '0;
            r_dval     <= 1'b0;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_sel      <= w_sel_next;
            r_err_sel  <= adc_chnsel_i;
            r_err_hold <= w_err_hold_next;
            r_sample   <= w_sample_next;
            r_d        <= w_d_next;
            r_dval     <= w_dval_next;
            r_busy     <= w_busy_next;
            r_err      <= w_err_next;
        end
    end

    assign adc_d_o     = r_d;
    assign adc_d_val_o = r_dval;
    assign adc_busy_o  = r_busy;
    assign adc_err_o   = r_err;

endmodule

// File: tb/tb_ast_adc_rsp.sv
// Randomized bench for ast_adc_rsp: expected pulse times, counts and results come from
// latency arithmetic and a transaction-level result model.
module tb_ast_adc_rsp;

    localparam int NCH  = 2;
    localparam int W    = 10;
    localparam int PWR  = 8;
    localparam int CONV = 12;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               pd = 1'b1;
    logic [NCH-1:0]     sel = '0;
    logic [NCH*W-1:0]   vals = '0;
    logic [W-1:0]       d;
    logic               dval;
    logic               busy;
    logic               err;

    always #5 clk = ~clk;

    ast_adc_rsp #(
        .AdcChannels  (NCH),
        .AdcDataWidth (W),
        .PwrUpCyc     (PWR),
        .ConvCyc      (CONV)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .adc_pd_i     (pd),
        .adc_chnsel_i (sel),
        .chn_val_i    (vals),
        .adc_d_o      (d),
        .adc_d_val_o  (dval),
        .adc_busy_o   (busy),
        .adc_err_o    (err)
    );

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Event monitor, sampled mid-cycle.
    int       n_val = 0, n_err = 0, n_busy = 0, n_ovl = 0;
    int       val_stamp = -1, err_stamp = -1;
    logic [W-1:0] val_data = '0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (dval) begin
                n_val++;
                val_stamp = edge_cnt;
                val_data  = d;
            end
            if (err) begin
                n_err++;
                err_stamp = edge_cnt;
            end
            if (busy) n_busy++;
            if (dval && err) n_ovl++;
        end
    end

    int vecs = 0;
    int miscmp = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        if (obs !== exp) begin
            miscmp++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    int s_val, s_err, s_busy;
    task automatic snap();
        s_val  = n_val;
        s_err  = n_err;
        s_busy = n_busy;
    endtask

`ifdef AST_ADC_NOISE_EN
    logic [7:0] m_lfsr = 8'hA5;
`endif

    // Expected result of one completed conversion of sample v.
    function automatic logic [W-1:0] model_result(input logic [W-1:0] v);
`ifdef AST_ADC_NOISE_EN
        int r;
        r = int'(v);
        if (m_lfsr[1:0] == 2'b01) r = r + 1;
        if (m_lfsr[1:0] == 2'b10) r = r - 1;
        if (r < 0) r = 0;
        if (r > (1 << W) - 1) r = (1 << W) - 1;
        m_lfsr = {1'b0, m_lfsr[7:1]} ^ (m_lfsr[0] ? 8'hB8 : 8'h00);
        return W'(r);
`else
        return v;
`endif
    endfunction

    function automatic logic [W-1:0] pick_val();
        case ($urandom_range(0, 3))
            0:       return '0;
            1:       return '1;
            default: return W'($urandom);
        endcase
    endfunction

    task automatic run_conv(input int ch, input logic [W-1:0] v, input int chg_at, input int hold);
        int e;
        logic [W-1:0] exp;
        vals[ch*W +: W] = v;
        sel = NCH'(1) << ch;
        snap();
        e   = edge_cnt;
        exp = model_result(v);
        tick(chg_at);
        vals[ch*W +: W] = W'($urandom);
        tick(CONV + 3 - chg_at);
        chk("conv_nval", n_val - s_val, 1);
        chk("conv_stamp", val_stamp, e + 1 + CONV);
        chk("conv_data", val_data, exp);
        chk("conv_nerr", n_err - s_err, 0);
        chk("conv_busy", n_busy - s_busy, CONV);
        tick(hold);
        chk("hold_nval", n_val - s_val, 1);
        chk("hold_d", d, exp);
        $display("conv ch=%0d sample=%h result=%h hold=%0d", ch, v, val_data, hold);
        sel = '0;
        tick(2);
    endtask

    task automatic run_abort(input int ch, input int k);
        int e;
        vals[ch*W +: W] = W'($urandom);
        sel = NCH'(1) << ch;
        snap();
        e = edge_cnt;
        tick(k);
        sel = NCH'(1) << (1 - ch);
        tick(1);
        sel = '0;
        tick(CONV + 2);
        chk("abort_nerr", n_err - s_err, 1);
        chk("abort_stamp", err_stamp, e + k + 1);
        chk("abort_nval", n_val - s_val, 0);
        $display("abort ch=%0d at conv cycle %0d", ch, k);
    endtask

    task automatic run_multi(input int hold);
        int e;
        sel = '1;
        snap();
        e = edge_cnt;
        tick(hold);
        sel = '0;
        tick(2);
        chk("multi_nerr", n_err - s_err, 1);
        chk("multi_stamp", err_stamp, e + 1);
        chk("multi_busy", n_busy - s_busy, 0);
        chk("multi_nval", n_val - s_val, 0);
        $display("multi-hot select held %0d cycles", hold);
    endtask

    // Power down k cycles into a conversion, then power back up with a select already pending.
    task automatic run_pd(input int ch, input int k);
        int e;
        logic [W-1:0] v;
        logic [W-1:0] exp;
        vals[ch*W +: W] = W'($urandom);
        sel = NCH'(1) << ch;
        snap();
        tick(k);
        pd = 1'b1;
        tick(3);
        chk("pd_d", d, 0);
        chk("pd_busy", busy, 0);
        chk("pd_nval", n_val - s_val, 0);
        chk("pd_nerr", n_err - s_err, 0);
        sel = '0;
        tick(2);
        v = pick_val();
        vals[ch*W +: W] = v;
        sel = NCH'(1) << ch;
        snap();
        e = edge_cnt;
        exp = model_result(v);
        pd = 1'b0;
        tick(PWR + CONV + 4);
        chk("repwr_nval", n_val - s_val, 1);
        chk("repwr_stamp", val_stamp, e + 2 + PWR + CONV);
        chk("repwr_data", val_data, exp);
        chk("repwr_busy", n_busy - s_busy, PWR + CONV);
        $display("powerdown at conv cycle %0d, repowered result=%h", k, val_data);
        sel = '0;
        tick(2);
    endtask

    task automatic run_reset(input int ch);
        int e;
        logic [W-1:0] v;
        logic [W-1:0] exp;
        v = pick_val();
        vals[ch*W +: W] = v;
        sel = NCH'(1) << ch;
        tick(5);
        rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_dval", dval, 0);
        chk("arst_d", d, 0);
        #2;
        rst_n = 1'b1;
`ifdef AST_ADC_NOISE_EN
        m_lfsr = 8'hA5;
`endif
        snap();
        e = edge_cnt;
        exp = model_result(v);
        tick(PWR + CONV + 5);
        chk("arst_nval", n_val - s_val, 1);
        chk("arst_stamp", val_stamp, e + 2 + PWR + CONV);
        chk("arst_data", val_data, exp);
        $display("async reset mid-conversion, recovered result=%h", val_data);
        sel = '0;
        tick(2);
    endtask

    initial begin
        int e;
        logic [W-1:0] exp;

        tick(3);
        chk("rst_d", d, 0);
        chk("rst_dval", dval, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        rst_n = 1'b1;
        snap();
        tick(4);
        chk("off_busy", n_busy - s_busy, 0);

        // Power-up with the select arriving during PWRUP.
        vals[W-1:0] = 10'h155;
        snap();
        e = edge_cnt;
        exp = model_result(10'h155);
        pd = 1'b0;
        tick(2);
        sel = 2'b01;
        tick(7);
        chk("pwrup_busy", n_busy - s_busy, PWR);
        tick(PWR + CONV - 5);
        chk("first_nval", n_val - s_val, 1);
        chk("first_stamp", val_stamp, e + 2 + PWR + CONV);
        chk("first_data", val_data, exp);
        chk("first_busy", n_busy - s_busy, PWR + CONV);
        $display("powerup conv sample=155 result=%h", val_data);

        // Request held in DONE, then released and a new one issued.
        snap();
        tick(20);
        chk("held_nval", n_val - s_val, 0);
        sel = '0;
        tick(1);
        run_conv(1, 10'h3FF, 4, 1);
        run_multi(5);
        run_abort(0, 5);
        run_pd(0, 6);
        run_pd(1, 12);
        run_conv(0, 10'h100, 3, 0);
        run_reset(1);

        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 9))
                0:       run_abort($urandom_range(0, 1), $urandom_range(1, 11));
                1:       run_pd($urandom_range(0, 1), $urandom_range(1, 12));
                2:       run_multi($urandom_range(1, 6));
                default: run_conv($urandom_range(0, 1), pick_val(),
                                  $urandom_range(1, 11), $urandom_range(0, 5));
            endcase
        end
        run_reset(0);

        chk("val_err_overlap", n_ovl, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
        $finish;
    end

endmodule

// File: doc/ast_adc_rsp.md
Name: ast_adc_rsp

Overview:
- Responder (AST-side) end of the ADC request/response interface.
- Takes the controller's request (`channel_sel`, `pd`) and returns the response (`data`, `data_valid`) with the same field packing as the `adc_ast_req_t` / `adc_ast_rsp_t` package types.
- Models power-up delay, per-channel conversion latency and the one-hot channel handshake.
- Analog inputs are represented by digital per-channel sample values, so the block serves both as the top-level AST ADC behavioural responder and as a bench agent for `adc_ctrl`.

Parameters:
- `AdcChannels`, 2, number of channels; `channel_sel` width.
- `AdcDataWidth`, 10, conversion result width.
- `PwrUpCyc`, 8, cycles from `pd` deassertion until the converter is ready (≥1).
- `ConvCyc`, 12, cycles from accepted one-hot `channel_sel` to `data_valid` (≥2).

Ports:
- `clk_i`  in  1  ADC clock.
- `rst_ni`  in  1  asynchronous active-low reset.
- `adc_pd_i`  in  1  power-down request; 1 = converter off.
- `adc_chnsel_i`  in  `AdcChannels`  channel select; must be one-hot to start a conversion.
- `chn_val_i`  in  `AdcChannels*AdcDataWidth`  per-channel sample values; channel k occupies bits [k*W +: W].
- `adc_d_o`  out  `AdcDataWidth`  conversion result.
- `adc_d_val_o`  out  1  result-valid pulse.
- `adc_busy_o`  out  1  1 while in PWRUP or CONV.
- `adc_err_o`  out  1  single-cycle pulse on a protocol violation.

Behaviour:
- Reset: state OFF, all outputs 0, counters 0, stored channel 0.
- All outputs are registered.
- Counter width is `$clog2(max(PwrUpCyc, ConvCyc)+1)`.
- States:
  - OFF: stays while `adc_pd_i`=1. On `adc_pd_i`=0, load counter with `PwrUpCyc` and go to PWRUP.
  - PWRUP: counter decrements each cycle. Reaching 0 goes to IDLE. `channel_sel` is ignored in this state.
  - IDLE:
    - `chnsel`==0: stay.
    - `chnsel` one-hot: capture channel index and sampled value `chn_val_i[idx]`, load counter with `ConvCyc`-1, go to CONV.
    - `chnsel` with >1 bit set: pulse `adc_err_o` once (not repeated while the value holds), stay in IDLE.
  - CONV:
    - Counter decrements. When it reaches 0, go to DONE.
    - If `chnsel` changes from the captured value: abort, pulse `adc_err_o`, go to IDLE. No `data_valid` is produced for an aborted conversion.
  - DONE: entry cycle drives `adc_d_o` with the captured sample and `adc_d_val_o`=1 for exactly 1 cycle. Then wait for `chnsel`==0 (request release) before returning to IDLE. No new conversion starts while `chnsel` is still held.
- Latency: one-hot `chnsel` sampled in IDLE at edge N gives `adc_d_val_o`=1 in the cycle after edge N+`ConvCyc`.
- `adc_d_o` holds the last result until the next valid or until power-down.
- Sample value is captured at conversion start; later `chn_val_i` changes do not affect the result.
- `adc_pd_i`=1 in any state: next cycle go to OFF; `adc_d_o`, `adc_d_val_o`, `adc_busy_o` cleared. An in-flight conversion is dropped with no error pulse.
- `adc_pd_i` deasserted while `chnsel` is already one-hot: the conversion starts only after PWRUP completes, on the first IDLE cycle.
- Simultaneous `pd` rise and conversion completion: `pd` wins; no valid pulse.
- Async reset mid-conversion: immediate return to reset values. No valid pulse after reset release until a full PWRUP + CONV sequence has completed.
- `adc_d_val_o` and `adc_err_o` are never asserted in the same cycle.

Optional Feature:
- Macro: `AST_ADC_NOISE_EN`.
- Defined:
  - An 8-bit Galois LFSR (taps x^8+x^6+x^5+x^4+1, seed 8'hA5 at reset) advances once per completed conversion.
  - The result is the captured value plus a signed dither {-1, 0, +1}, chosen by LFSR[1:0] = {00: 0, 01: +1, 10: -1, 11: 0}.
  - The sum saturates to [0, 2^W-1].
  - LFSR is held in OFF.
- Not defined: result equals the captured sample exactly; no LFSR logic is present.

Test Plan (defaults, macro undefined unless stated):
- Power-up and conversion:
  - Stimulus: reset release, `pd`=0 at cycle 0, `chnsel`=2'b01 from cycle 2, `chn_val_i[9:0]`=10'h155.
  - Required response: `busy` for the 8 cycles of PWRUP. `adc_d_val_o`=1 for one cycle, 12 cycles after `chnsel` is first sampled in IDLE, with `adc_d_o`=10'h155.
- Request held, then released:
  - Stimulus: after that valid, keep `chnsel`=01 for 20 cycles, then 00, then 2'b10 with `chn_val_i[19:10]`=10'h3FF.
  - Required response: no second valid while held; next valid gives 10'h3FF, 12 cycles after the new select.
- Protocol errors:
  - Stimulus: `chnsel`=2'b11 held 5 cycles in IDLE.
  - Required response: exactly one `adc_err_o` pulse, no busy.
  - Stimulus: `chnsel` switched from 01 to 10 at CONV cycle 5.
  - Required response: one err pulse, no valid, return to IDLE.
- Power-down mid-conversion:
  - Stimulus: `pd`=1 at CONV cycle 6.
  - Required response: `adc_d_o`=0, valid never asserted; after `pd`=0 a fresh 8-cycle PWRUP occurs.
- Sample capture:
  - Stimulus: `chn_val_i` changes 10'h100 → 10'h200 during CONV.
  - Required response: result is 10'h100.
- `AST_ADC_NOISE_EN` defined:
  - Stimulus: 64 conversions of 10'h000 and of 10'h3FF.
  - Required response: results stay within {0, 1} and {3FE, 3FF} respectively (saturation holds); the sequence is reproducible from seed 8'hA5.
